multiport_reg_file: RTL and testbench
=====================================

Name: multiport_reg_file

Overview:
- Parametrised successor to the single-write, two-read 64-bit register file.
- Configurable width, depth and read-port count, plus a pending-write scoreboard that tracks destination registers of in-flight instructions.
- Sits between decode/issue (scoreboard set, operand reads) and writeback (data write, scoreboard clear).
- Gives the pipeline hazard status per read operand and a count of outstanding writes.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; power of two, minimum 2.
- NREAD, 2, number of read ports, 1..4.
- AW, $clog2(NREGS), register index width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NREAD*AW  packed read indices; port i is bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  packed read data, combinational.
- rd_busy  out  NREAD  port i source register has a pending write.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- iss_valid  in  1  issue request claiming a destination register.
- iss_rd  in  AW  destination being claimed.
- iss_ready  out  1  claim accepted this cycle.
- flush  in  1  squash: clear all pending claims.
- busy_count  out  AW+1  number of busy registers.

Behaviour:
- Reset (reset_n low, asynchronous): all registers 0, all busy bits 0, busy_count 0. Reset wins over every other input.
- Register 0 is hardwired:
  - reads return 0 and rd_busy is 0;
  - writes and claims to index 0 are ignored;
  - iss_ready is 1 for iss_rd=0, with no busy-count change.
- Reads are combinational: rd_data[i] = reg[rd_addr[i]]. All ports are independent, and any ports may address the same register.
- Write: on the rising edge with wb_en=1 and wb_addr≠0, reg[wb_addr] <= wb_data and busy[wb_addr] <= 0.
  - The write is performed even if busy is 0; a late writeback after a flush still updates data.
- Issue: iss_ready = !busy[iss_rd] || (wb_en && wb_addr==iss_rd) || iss_rd==0.
  - Combinational, and independent of iss_valid.
  - On the edge with iss_valid && iss_ready && iss_rd≠0, busy[iss_rd] <= 1.
  - When iss_ready=0 (WAW stall), the claim is dropped and the issuer must hold its request.
- Same-cycle writeback and issue to the same rd: data is written and busy ends at 1 (issue wins).
- flush=1 on an edge:
  - all busy bits go to 0 and busy_count goes to 0;
  - a concurrent issue claim is discarded;
  - a concurrent writeback still writes data.
- busy_count: registered population count of busy bits, updated on the same edge as the busy bits.
  - Per-cycle delta is +1 (accepted claim), −1 (writeback clearing a set bit), 0 (both on different registers, or neither), or 0 (writeback and claim on the same rd).
  - It can never exceed NREGS−1, so no saturation logic is required.
- rd_busy[i] = busy[rd_addr[i]] from the current registered state. No write bypass on the busy flag.
- Mid-operation reset clears every claim; writebacks already in flight after reset release are treated as ordinary writes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - a same-cycle writeback is forwarded to reads, so rd_data[i] = wb_data when wb_en && wb_addr==rd_addr[i] && wb_addr≠0;
  - rd_busy[i] is forced to 0 under the same condition.
- Undefined:
  - reads return the pre-edge register contents;
  - rd_busy reflects the unmodified busy bit.

Decomposition:
- Package rf_pkg: XLEN default, NREGS default, the reg-index typedef (logic [AW-1:0]), and the data-word typedef.
- Sub-module rf_scoreboard: busy vector, iss_ready logic, flush, and busy_count.
  - Inputs: clk, reset_n, the issue, writeback and flush signals, and the read indices.
  - Outputs: rd_busy, iss_ready, busy_count.
- The top level holds the storage array, read muxes and bypass.

Test Plan:
- Reset/x0: release reset_n; write 0xDEAD to reg 5, then issue a claim on rd 0 and write 0xFFFF to reg 0 → reg 5 reads 0xDEAD; reg 0 reads 0 with rd_busy 0; busy_count 0.
- Claim/stall/release: claim rd 7 → busy_count 1 and rd_busy=1 on a port reading 7. Claim 7 again → iss_ready 0, count stays 1. wb 7=0x1234 → busy clears, count 0, port reads 0x1234.
- Same-cycle wb+issue on rd 9 (after a prior claim): wb 9=0x55 with iss_rd 9 → iss_ready 1; data 0x55; busy[9] stays 1; count unchanged at 1.
- Flush: claim regs 3, 4, 5 → count 3. Assert flush together with iss 6 and wb 3=0xAA → count 0, all busy 0, reg 6 unclaimed, reg 3 reads 0xAA.
- Bypass: with NREAD=3 and all ports on reg 12, wb 12=0x77 in the same cycle.
  - With REGFILE_BYPASS_EN, all ports read 0x77 that cycle.
  - Without it, all ports read the old value that cycle and 0x77 the next.
- Async reset mid-run: with 4 claims pending and reset_n pulsed low mid-cycle → immediate count 0 and all registers 0, without waiting for a clock edge.

Source files
------------

// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared defaults and types for the multiport register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int RF_XLEN  = 64;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0]   reg_idx_t;
  typedef logic [RF_XLEN-1:0] xword_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-write busy vector, issue acceptance and busy count.
//               Optional macro: REGFILE_BYPASS_EN (masks rd_busy on same-cycle wb).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    rd_busy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush,
  output logic [AW:0]         busy_count
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             wb_live, claim, inc, dec;

  assign wb_live   = wb_en && (wb_addr != '0);
  assign iss_ready = (iss_rd == '0) || !busy_q[iss_rd] || (wb_en && (wb_addr == iss_rd));
  assign claim     = iss_valid && iss_ready && (iss_rd != '0) && !flush;

  // A claim landing on a register that a same-cycle writeback releases nets to zero.
  assign inc = claim && !busy_q[iss_rd];
  assign dec = wb_live && busy_q[wb_addr] && !(claim && (iss_rd == wb_addr));

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q + (AW+1)'(inc) - (AW+1)'(dec);
    if (wb_live) busy_d[wb_addr] = 1'b0;
    if (claim)   busy_d[iss_rd]  = 1'b1;
    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_busy
      logic [AW-1:0] addr;
      assign addr = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign rd_busy[i] = busy_q[addr] && (addr != '0) && !(wb_en && (wb_addr == addr));
`else
      assign rd_busy[i] = busy_q[addr] && (addr != '0);
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/multiport_reg_file.sv
// ============================================================================
// Module      : multiport_reg_file
// Description : Parametrised register file with N read ports and a pending-write
//               scoreboard. Optional macro: REGFILE_BYPASS_EN (write-to-read forward).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiport_reg_file
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_ready,
  input  logic                  flush,
  output logic [AW:0]           busy_count
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_addr != '0)) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '{default: '0};
    else          regs_q <= regs_d;
  end

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] word;
      assign addr = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign word = (addr == '0) ? '0 :
                    (wb_en && (wb_addr == addr)) ? wb_data : regs_q[addr];
`else
      assign word = (addr == '0) ? '0 : regs_q[addr];
`endif
      assign rd_data[i*XLEN +: XLEN] = word;
    end
  endgenerate

  rf_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .flush      (flush),
    .busy_count (busy_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_multiport_reg_file.sv
// ============================================================================
// Module      : tb_multiport_reg_file
// Description : Vector-table bench with a reference model and expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiport_reg_file;
  import rf_pkg::*;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 3;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wb_en;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;
  logic                  iss_ready;
  logic                  flush;
  logic [AW:0]           busy_count;

  always #5 clk = ~clk;

  multiport_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .flush(flush), .busy_count(busy_count)
  );

  typedef struct {
    logic     wb_en;
    reg_idx_t wb_addr;
    xword_t   wb_data;
    logic     iss_valid;
    reg_idx_t iss_rd;
    logic     flush;
    reg_idx_t ra0, ra1, ra2;
    logic     exp_ready;
    int       exp_count;
  } vec_t;

  typedef struct {
    xword_t          d0, d1, d2;
    logic [NREAD-1:0] busy;
    logic            ready;
  } exp_t;

  vec_t   vecs[$];
  exp_t   expq[$];
  xword_t mregs [NREGS];
  logic   mbusy [NREGS];
  int     mcount;
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic we, input reg_idx_t wa, input xword_t wd,
                     input logic iv, input reg_idx_t ir, input logic fl,
                     input reg_idx_t a0, input reg_idx_t a1, input reg_idx_t a2,
                     input logic er, input int ec);
    vec_t v;
    v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
    v.iss_valid = iv; v.iss_rd = ir; v.flush = fl;
    v.ra0 = a0; v.ra1 = a1; v.ra2 = a2;
    v.exp_ready = er; v.exp_count = ec;
    vecs.push_back(v);
  endtask

  function automatic void model_read(input vec_t v, input reg_idx_t a,
                                     output xword_t d, output logic b);
    d = (a == 0) ? '0 : mregs[a];
    b = (a == 0) ? 1'b0 : mbusy[a];
`ifdef REGFILE_BYPASS_EN
    if (v.wb_en && v.wb_addr == a && a != 0) begin
      d = v.wb_data;
      b = 1'b0;
    end
`endif
  endfunction

  function automatic logic model_ready(input vec_t v);
    return (v.iss_rd == 0) || !mbusy[v.iss_rd] || (v.wb_en && v.wb_addr == v.iss_rd);
  endfunction

  task automatic model_edge(input vec_t v);
    logic rdy;
    rdy = model_ready(v);
    if (v.wb_en && v.wb_addr != 0) begin
      mregs[v.wb_addr] = v.wb_data;
      mbusy[v.wb_addr] = 1'b0;
    end
    if (v.flush) begin
      for (int r = 0; r < NREGS; r++) mbusy[r] = 1'b0;
    end else if (v.iss_valid && rdy && v.iss_rd != 0) begin
      mbusy[v.iss_rd] = 1'b1;
    end
    mcount = 0;
    for (int r = 0; r < NREGS; r++) mcount += int'(mbusy[r]);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mregs[r] = '0;
      mbusy[r] = 1'b0;
    end
    mcount = 0;
  endtask

  task automatic drive_idle();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  initial begin
    exp_t e, g;
    vec_t v;
    logic b;

    reset_n = 1'b0;
    rd_addr = '0;
    drive_idle();
    model_reset();

    //   wb  wa  wdata        iv  ir  fl  ra0 ra1 ra2 rdy cnt
    add(1, 5,  64'hDEAD,      0, 0,  0,  5,  0,  0,  1,  0);
    add(0, 0,  0,             1, 0,  0,  5,  0,  0,  1,  0);
    add(1, 0,  64'hFFFF,      0, 0,  0,  0,  5,  0,  1,  0);
    add(0, 0,  0,             1, 7,  0,  0,  5,  7,  1,  1);
    add(0, 0,  0,             1, 7,  0,  7,  7,  0,  0,  1);
    add(1, 7,  64'h1234,      0, 0,  0,  7,  5,  0,  1,  0);
    add(0, 0,  0,             1, 9,  0,  7,  9,  0,  1,  1);
    add(1, 9,  64'h55,        1, 9,  0,  9,  9,  7,  1,  1);
    add(1, 9,  64'h56,        0, 0,  0,  9,  0,  0,  1,  0);
    add(0, 0,  0,             1, 3,  0,  9,  3,  0,  1,  1);
    add(0, 0,  0,             1, 4,  0,  3,  4,  0,  1,  2);
    add(0, 0,  0,             1, 5,  0,  3,  4,  5,  1,  3);
    add(1, 3,  64'hAA,        1, 6,  1,  3,  4,  6,  1,  0);
    add(1, 12, 64'h11,        0, 0,  0,  3,  6,  5,  1,  0);
    add(1, 12, 64'h77,        0, 0,  0,  12, 12, 12, 1,  0);
    add(0, 0,  0,             1, 1,  0,  12, 12, 12, 1,  1);
    add(0, 0,  0,             1, 2,  0,  1,  2,  0,  1,  2);
    add(0, 0,  0,             1, 3,  0,  1,  2,  3,  1,  3);
    add(0, 0,  0,             1, 4,  0,  1,  2,  4,  1,  4);

    #12;
    check("reset_count", 64'(busy_count), 64'd0);
    check("reset_busy",  64'(rd_busy),    64'd0);
    check("reset_ready", 64'(iss_ready),  64'd1);

    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      v = vecs[k];
      @(negedge clk);
      wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
      iss_valid = v.iss_valid; iss_rd = v.iss_rd; flush = v.flush;
      rd_addr = {v.ra2, v.ra1, v.ra0};
      model_read(v, v.ra0, e.d0, b); e.busy[0] = b;
      model_read(v, v.ra1, e.d1, b); e.busy[1] = b;
      model_read(v, v.ra2, e.d2, b); e.busy[2] = b;
      e.ready = model_ready(v);
      check($sformatf("v%0d_table_ready", k), 64'(e.ready), 64'(v.exp_ready));
      expq.push_back(e);
      #1;
      g = expq.pop_front();
      check($sformatf("v%0d_ready", k), 64'(iss_ready), 64'(g.ready));
      check($sformatf("v%0d_rd0", k),   rd_data[0*XLEN +: XLEN], g.d0);
      check($sformatf("v%0d_rd1", k),   rd_data[1*XLEN +: XLEN], g.d1);
      check($sformatf("v%0d_rd2", k),   rd_data[2*XLEN +: XLEN], g.d2);
      check($sformatf("v%0d_busy", k),  64'(rd_busy), 64'(g.busy));
      @(posedge clk);
      model_edge(v);
      #1;
      check($sformatf("v%0d_count", k), 64'(busy_count), 64'(v.exp_count));
      check($sformatf("v%0d_count_model", k), 64'(busy_count), 64'(mcount));
    end

    // Bypass corner: write and read of reg 12 share a cycle, then the next cycle.
    @(negedge clk);
    drive_idle();
    rd_addr = {5'd12, 5'd12, 5'd12};
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 64'h99;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_cycle", rd_data[2*XLEN +: XLEN], 64'h99);
`else
    check("byp_same_cycle", rd_data[2*XLEN +: XLEN], 64'h77);
`endif
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    #1;
    check("byp_next_cycle", rd_data[0*XLEN +: XLEN], 64'h99);

    // Asynchronous reset between edges with four claims pending.
    @(negedge clk);
    drive_idle();
    rd_addr = {5'd12, 5'd5, 5'd3};
    #1;
    check("pre_areset_count", 64'(busy_count), 64'd4);
    check("pre_areset_busy",  64'(rd_busy),    64'b001);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("areset_count", 64'(busy_count), 64'd0);
    check("areset_rd0",   rd_data[0*XLEN +: XLEN], 64'd0);
    check("areset_rd1",   rd_data[1*XLEN +: XLEN], 64'd0);
    check("areset_rd2",   rd_data[2*XLEN +: XLEN], 64'd0);
    check("areset_busy",  64'(rd_busy), 64'd0);
    #1;
    reset_n = 1'b1;

    // Write after reset release behaves as an ordinary write.
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'hBEEF;
    @(posedge clk);
    #1;
    drive_idle();
    #1;
    check("post_reset_write", rd_data[0*XLEN +: XLEN], 64'hBEEF);
    check("post_reset_count", 64'(busy_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
